reaction_game_ctrl: RTL and testbench

REACTION_GAME_CTRL -- requirements
Module: reaction_game_ctrl

---
 rtl/reaction_game_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_reaction_game_ctrl.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_game_ctrl.sv
// Reaction-time game controller: sequences LED cues, external delay and
// reaction counters, and keeps per-game total, last and best scores.
module reaction_game_ctrl #(
  parameter int WIDTH   = 13,
  parameter int ROUNDS  = 3,
  parameter int TIMEOUT = 5000,
  parameter int PENALTY = 1000
) (
  input  logic             Clock,
  input  logic             CLRN,
  input  logic             buttonStart,
  input  logic             buttonHit,
  input  logic             buttonReset,
  input  logic             delayCounterDone,
  input  logic [WIDTH-1:0] scoreCounter,
  output logic             ledRed,
  output logic             ledGreen,
  output logic             delayCounterEnable,
  output logic             delayCounterClear,
  output logic             scoreCounterEnable,
  output logic             scoreCounterClear,
  output logic [WIDTH-1:0] displayScore,
  output logic [WIDTH-1:0] bestScore,
  output logic [3:0]       roundCount,
  output logic             falseStart,
  output logic             gameDone
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_GO    = 3'd3;
  localparam logic [2:0] S_FALSE = 3'd4;
  localparam logic [2:0] S_CAP   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  // Constants are clipped to the representable range so a large
  // TIMEOUT/PENALTY on a narrow build still behaves sensibly.
  localparam int MAXI  = (1 << WIDTH) - 1;
  localparam int TO_I  = (TIMEOUT > MAXI) ? MAXI : TIMEOUT;
  localparam int PEN_I = (PENALTY > MAXI) ? MAXI : PENALTY;

  localparam logic [WIDTH-1:0] TO_C  = TO_I[WIDTH-1:0];
  localparam logic [WIDTH-1:0] PEN_C = PEN_I[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONES  = {WIDTH{1'b1}};
  localparam logic [3:0]       RND_C = ROUNDS[3:0];

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [WIDTH-1:0] total_q, total_d;
  logic [WIDTH-1:0] best_q, best_d;
  logic [WIDTH-1:0] sample_q, sample_d;
  logic [3:0]       round_q, round_d;
  logic             blk_q, blk_d;
  logic             fs_q;

  logic [WIDTH:0]   sum;
  logic [3:0]       round_inc;
  logic             sc_ge_to;
  logic             smp_lt_best;
  logic             hit_ok;

  // Datapath arithmetic is one bit wider so overflow is visible.
  assign sum         = {1'b0, total_q} + {1'b0, sample_q};
  assign sc_ge_to    = {1'b0, scoreCounter} >= {1'b0, TO_C};
  assign smp_lt_best = {1'b0, sample_q} < {1'b0, best_q};
  assign round_inc   = round_q + 4'd1;

  // A hit held over from the previous round is masked until released.
  assign hit_ok = buttonHit & ~blk_q;

  // Next-state and score bookkeeping; soft reset overrides everything.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    total_d  = total_q;
    best_d   = best_q;
    sample_d = sample_q;
    round_d  = round_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (buttonStart) begin
          state_d = S_ARM;
          round_d = 4'd0;
          total_d = '0;
          last_d  = '0;
        end
      end
      S_ARM: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (hit_ok) begin
          state_d = S_FALSE;
        end else if (delayCounterDone) begin
          state_d = S_GO;
        end
      end
      S_GO: begin
        if (hit_ok) begin
          state_d  = S_CAP;
          sample_d = sc_ge_to ? TO_C : scoreCounter;
        end else if (sc_ge_to) begin
          state_d  = S_CAP;
          sample_d = TO_C;
        end
      end
      S_FALSE: begin
        if (!buttonHit) begin
          state_d  = S_CAP;
          sample_d = PEN_C;
        end
      end
      S_CAP: begin
        last_d  = sample_q;
        total_d = sum[WIDTH] ? ONES : sum[WIDTH-1:0];
        best_d  = smp_lt_best ? sample_q : best_q;
        round_d = round_inc;
        state_d = (round_inc == RND_C) ? S_DONE : S_ARM;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (buttonReset) begin
      state_d = S_IDLE;
      last_d  = '0;
      total_d = '0;
      round_d = 4'd0;
      best_d  = best_q;
    end
  end

  // Hit mask: set on capture, cleared once the button is seen low.
  always_comb begin
    blk_d = blk_q;
    if (state_q == S_CAP) begin
      blk_d = 1'b1;
    end else if (!buttonHit) begin
      blk_d = 1'b0;
    end
  end

  // State and score registers.
  always_ff @(posedge Clock or negedge CLRN) begin
    if (!CLRN) begin
      state_q  <= S_IDLE;
      last_q   <= '0;
      total_q  <= '0;
      best_q   <= ONES;
      sample_q <= '0;
      round_q  <= 4'd0;
      blk_q    <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      total_q  <= total_d;
      best_q   <= best_d;
      sample_q <= sample_d;
      round_q  <= round_d;
      blk_q    <= blk_d;
      fs_q     <= (state_q == S_FALSE);
    end
  end

  // Cue and counter-control decode from the current state.
  always_comb begin
    ledRed             = 1'b0;
    ledGreen           = 1'b0;
    delayCounterEnable = 1'b0;
    delayCounterClear  = 1'b0;
    scoreCounterEnable = 1'b0;
    scoreCounterClear  = 1'b0;
    gameDone           = 1'b0;
    unique case (state_q)
      S_IDLE, S_ARM: begin
        delayCounterClear = 1'b1;
        scoreCounterClear = 1'b1;
      end
      S_WAIT: begin
        ledRed             = 1'b1;
        delayCounterEnable = 1'b1;
      end
      S_GO: begin
        ledGreen           = 1'b1;
        scoreCounterEnable = 1'b1;
      end
      S_FALSE: begin
        ledRed   = 1'b1;
        ledGreen = 1'b1;
      end
      S_DONE: begin
        gameDone = 1'b1;
      end
      default: begin
        gameDone = 1'b0;
      end
    endcase
  end

  // falseStart only on the first FALSE cycle; fs_q remembers the last one.
  assign falseStart   = (state_q == S_FALSE) & ~fs_q;
  assign displayScore = (state_q == S_DONE) ? total_q : last_q;
  assign bestScore    = best_q;
  assign roundCount   = round_q;

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Directed bench for reaction_game_ctrl: a default-width instance plus a
// 10-bit instance used for total saturation.
module tb_reaction_game_ctrl;

  logic clk = 1'b0;
  logic clrn;

  logic        start, hit, rst, dd;
  logic [12:0] sc;
  logic        red, green, den, dclr, sen, sclr, fs, gd;
  logic [12:0] disp, best;
  logic [3:0]  rnd;

  logic        start1, hit1, rst1, dd1;
  logic [9:0]  sc1;
  logic        red1, green1, den1, dclr1, sen1, sclr1, fs1, gd1;
  logic [9:0]  disp1, best1;
  logic [3:0]  rnd1;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  reaction_game_ctrl u0 (
    .Clock(clk), .CLRN(clrn),
    .buttonStart(start), .buttonHit(hit),
    .buttonReset(rst), .delayCounterDone(dd),
    .scoreCounter(sc),
    .ledRed(red), .ledGreen(green),
    .delayCounterEnable(den), .delayCounterClear(dclr),
    .scoreCounterEnable(sen), .scoreCounterClear(sclr),
    .displayScore(disp), .bestScore(best),
    .roundCount(rnd), .falseStart(fs), .gameDone(gd)
  );

  reaction_game_ctrl #(
    .WIDTH(10), .ROUNDS(3), .TIMEOUT(500), .PENALTY(100)
  ) u1 (
    .Clock(clk), .CLRN(clrn),
    .buttonStart(start1), .buttonHit(hit1),
    .buttonReset(rst1), .delayCounterDone(dd1),
    .scoreCounter(sc1),
    .ledRed(red1), .ledGreen(green1),
    .delayCounterEnable(den1), .delayCounterClear(dclr1),
    .scoreCounterEnable(sen1), .scoreCounterClear(sclr1),
    .displayScore(disp1), .bestScore(best1),
    .roundCount(rnd1), .falseStart(fs1), .gameDone(gd1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ARM -> WAIT -> GO
  task automatic arm_to_go();
    tick();
    dd = 1'b1;
    tick();
    dd = 1'b0;
  endtask

  // From ARM: play one round hit at v, end after CAPTURE.
  task automatic hit_round(input logic [12:0] v);
    arm_to_go();
    sc  = v;
    hit = 1'b1;
    tick();
    hit = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    clrn = 1'b1;
    #1 clrn = 1'b0;
    #1;
    vecs++;
    if ({sclr, dclr} !== 2'b11) begin
      errs++;
      $display("FAIL rst_clr got %b want 11", {sclr, dclr});
    end
    vecs++;
    if ({red, green, den, sen, fs, gd} !== 6'b0) begin
      errs++;
      $display("FAIL rst_outs got %b want 000000",
               {red, green, den, sen, fs, gd});
    end
    vecs++;
    if (best !== 13'd8191) begin
      errs++;
      $display("FAIL rst_best got %0d want 8191", best);
    end
    vecs++;
    if (disp !== 13'd0 || rnd !== 4'd0) begin
      errs++;
      $display("FAIL rst_disp_rnd got %0d/%0d want 0/0", disp, rnd);
    end
    vecs++;
    if ({red1, green1, den1, sen1, fs1, gd1, sclr1, dclr1} !== 8'b00000011
        || best1 !== 10'd1023) begin
      errs++;
      $display("FAIL rst_u1 got %b best %0d want 00000011 best 1023",
               {red1, green1, den1, sen1, fs1, gd1, sclr1, dclr1}, best1);
    end
    @(negedge clk);
    clrn = 1'b1;
    tick();
    vecs++;
    if ({sclr, dclr, gd} !== 3'b110) begin
      errs++;
      $display("FAIL idle_hold got %b want 110", {sclr, dclr, gd});
    end
  endtask

  task automatic test_three_rounds();
    start = 1'b1;
    tick();
    start = 1'b0;
    vecs++;
    if ({sclr, dclr, red} !== 3'b110) begin
      errs++;
      $display("FAIL arm_dec got %b want 110", {sclr, dclr, red});
    end
    tick();
    vecs++;
    if ({red, green, den, sen} !== 4'b1010) begin
      errs++;
      $display("FAIL wait_dec got %b want 1010", {red, green, den, sen});
    end
    dd = 1'b1;
    tick();
    dd = 1'b0;
    vecs++;
    if ({red, green, den, sen} !== 4'b0101) begin
      errs++;
      $display("FAIL go_dec got %b want 0101", {red, green, den, sen});
    end
    sc  = 13'd120;
    hit = 1'b1;
    tick();
    hit = 1'b0;
    vecs++;
    if ({red, green, den, sen, sclr, dclr} !== 6'b0) begin
      errs++;
      $display("FAIL cap_dec got %b want 000000",
               {red, green, den, sen, sclr, dclr});
    end
    tick();
    vecs++;
    if (disp !== 13'd120 || rnd !== 4'd1 || best !== 13'd120) begin
      errs++;
      $display("FAIL r1 got %0d/%0d/%0d want 120/1/120", disp, rnd, best);
    end
    hit_round(13'd80);
    vecs++;
    if (disp !== 13'd80 || rnd !== 4'd2 || best !== 13'd80) begin
      errs++;
      $display("FAIL r2 got %0d/%0d/%0d want 80/2/80", disp, rnd, best);
    end
    hit_round(13'd200);
    vecs++;
    if (disp !== 13'd400 || rnd !== 4'd3 || gd !== 1'b1
        || best !== 13'd80) begin
      errs++;
      $display("FAIL done got %0d/%0d/%b/%0d want 400/3/1/80",
               disp, rnd, gd, best);
    end
  endtask

  task automatic test_false_start();
    int pulses;
    int fcyc;
    pulses = 0;
    fcyc   = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    vecs++;
    if (disp !== 13'd0 || rnd !== 4'd0 || best !== 13'd80 || gd !== 1'b0) begin
      errs++;
      $display("FAIL restart got %0d/%0d/%0d/%b want 0/0/80/0",
               disp, rnd, best, gd);
    end
    tick();
    hit = 1'b1;
    tick();
    vecs++;
    if (fs !== 1'b1) begin
      errs++;
      $display("FAIL fs_first got %b want 1", fs);
    end
    for (int i = 0; i < 5; i++) begin
      if (fs) pulses++;
      if (red && green) fcyc++;
      if (i == 4) hit = 1'b0;
      tick();
    end
    vecs++;
    if (pulses != 1 || fcyc != 5) begin
      errs++;
      $display("FAIL fs_hold got %0d pulses %0d cycles want 1/5",
               pulses, fcyc);
    end
    vecs++;
    if ({red, green} !== 2'b00) begin
      errs++;
      $display("FAIL fs_cap got %b want 00", {red, green});
    end
    tick();
    vecs++;
    if (disp !== 13'd1000 || rnd !== 4'd1 || best !== 13'd80) begin
      errs++;
      $display("FAIL fs_score got %0d/%0d/%0d want 1000/1/80",
               disp, rnd, best);
    end
  endtask

  task automatic test_timeout();
    arm_to_go();
    sc = 13'd4999;
    tick();
    vecs++;
    if ({green, sen} !== 2'b11) begin
      errs++;
      $display("FAIL to_4999 got %b want 11", {green, sen});
    end
    sc = 13'd5000;
    tick();
    vecs++;
    if ({green, sen} !== 2'b00) begin
      errs++;
      $display("FAIL to_5000 got %b want 00", {green, sen});
    end
    sc = 13'd0;
    tick();
    vecs++;
    if (disp !== 13'd5000 || rnd !== 4'd2) begin
      errs++;
      $display("FAIL to_score got %0d/%0d want 5000/2", disp, rnd);
    end
    hit_round(13'd5003);
    vecs++;
    if (disp !== 13'd8191 || gd !== 1'b1 || rnd !== 4'd3) begin
      errs++;
      $display("FAIL to_sat got %0d/%b/%0d want 8191/1/3", disp, gd, rnd);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    hit_round(13'd5003);
    vecs++;
    if (disp !== 13'd5000 || rnd !== 4'd1) begin
      errs++;
      $display("FAIL hit_5003 got %0d/%0d want 5000/1", disp, rnd);
    end
  endtask

  task automatic test_hit_priority();
    tick();
    hit = 1'b1;
    dd  = 1'b1;
    tick();
    vecs++;
    if ({red, green, fs, sen} !== 4'b1110) begin
      errs++;
      $display("FAIL prio got %b want 1110", {red, green, fs, sen});
    end
    hit = 1'b0;
    dd  = 1'b0;
    tick();
    tick();
    vecs++;
    if (disp !== 13'd1000 || rnd !== 4'd2) begin
      errs++;
      $display("FAIL prio_score got %0d/%0d want 1000/2", disp, rnd);
    end
  endtask

  task automatic test_clrn_mid_go();
    arm_to_go();
    sc = 13'd50;
    vecs++;
    if (green !== 1'b1) begin
      errs++;
      $display("FAIL pre_clrn got %b want 1", green);
    end
    #2 clrn = 1'b0;
    #1;
    vecs++;
    if ({sclr, dclr, red, green, den, sen, fs, gd} !== 8'b11000000) begin
      errs++;
      $display("FAIL clrn_outs got %b want 11000000",
               {sclr, dclr, red, green, den, sen, fs, gd});
    end
    vecs++;
    if (best !== 13'd8191 || disp !== 13'd0 || rnd !== 4'd0) begin
      errs++;
      $display("FAIL clrn_regs got %0d/%0d/%0d want 8191/0/0",
               best, disp, rnd);
    end
    @(negedge clk);
    clrn = 1'b1;
    sc   = 13'd0;
  endtask

  task automatic test_soft_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    hit_round(13'd300);
    vecs++;
    if (disp !== 13'd300 || rnd !== 4'd1 || best !== 13'd300) begin
      errs++;
      $display("FAIL sr_r1 got %0d/%0d/%0d want 300/1/300", disp, rnd, best);
    end
    arm_to_go();
    sc  = 13'd40;
    rst = 1'b1;
    hit = 1'b1;
    tick();
    rst = 1'b0;
    hit = 1'b0;
    vecs++;
    if ({sclr, dclr, red, green, gd} !== 5'b11000) begin
      errs++;
      $display("FAIL sr_idle got %b want 11000", {sclr, dclr, red, green, gd});
    end
    vecs++;
    if (rnd !== 4'd0 || disp !== 13'd0 || best !== 13'd300) begin
      errs++;
      $display("FAIL sr_regs got %0d/%0d/%0d want 0/0/300", rnd, disp, best);
    end
  endtask

  task automatic test_back_to_back();
    start = 1'b1;
    tick();
    start = 1'b0;
    arm_to_go();
    sc  = 13'd100;
    hit = 1'b1;
    tick();
    tick();
    vecs++;
    if (disp !== 13'd100 || best !== 13'd100) begin
      errs++;
      $display("FAIL b2b_r1 got %0d/%0d want 100/100", disp, best);
    end
    tick();
    tick();
    vecs++;
    if ({red, green, fs} !== 3'b100) begin
      errs++;
      $display("FAIL b2b_wait got %b want 100", {red, green, fs});
    end
    dd = 1'b1;
    tick();
    dd = 1'b0;
    sc = 13'd150;
    tick();
    vecs++;
    if ({red, green, sen} !== 3'b011) begin
      errs++;
      $display("FAIL b2b_go got %b want 011", {red, green, sen});
    end
    hit = 1'b0;
    tick();
    sc  = 13'd250;
    hit = 1'b1;
    tick();
    hit = 1'b0;
    tick();
    vecs++;
    if (disp !== 13'd250 || rnd !== 4'd2 || best !== 13'd100) begin
      errs++;
      $display("FAIL b2b_r2 got %0d/%0d/%0d want 250/2/100", disp, rnd, best);
    end
  endtask

  task automatic test_saturation();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int r = 0; r < 3; r++) begin
      tick();
      dd1 = 1'b1;
      tick();
      dd1 = 1'b0;
      if (r == 0) begin
        sc1 = 10'd499;
        tick();
        vecs++;
        if (green1 !== 1'b1) begin
          errs++;
          $display("FAIL sat_499 got %b want 1", green1);
        end
      end
      sc1 = 10'd500;
      tick();
      sc1 = 10'd0;
      tick();
      if (r == 0) begin
        vecs++;
        if (disp1 !== 10'd500) begin
          errs++;
          $display("FAIL sat_r1 got %0d want 500", disp1);
        end
      end
    end
    vecs++;
    if (disp1 !== 10'd1023 || gd1 !== 1'b1 || rnd1 !== 4'd3
        || best1 !== 10'd500) begin
      errs++;
      $display("FAIL sat_done got %0d/%b/%0d/%0d want 1023/1/3/500",
               disp1, gd1, rnd1, best1);
    end
  endtask

  initial begin
    start  = 1'b0;
    hit    = 1'b0;
    rst    = 1'b0;
    dd     = 1'b0;
    sc     = 13'd0;
    start1 = 1'b0;
    hit1   = 1'b0;
    rst1   = 1'b0;
    dd1    = 1'b0;
    sc1    = 10'd0;
    test_reset();
    test_three_rounds();
    test_false_start();
    test_timeout();
    test_hit_priority();
    test_clrn_mid_go();
    test_soft_reset();
    test_back_to_back();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
